// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one full-subtractor cell per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN; otherwise ovf is tied to 0.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  sa_q, sb_q, sd_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, bout_q;
  logic [W-1:0]  diff_q;

  logic          d_bit;
  logic          br_d;
  logic [W-1:0]  sd_d;
  logic          unused_sd0;

  // Full-subtractor cell: difference and borrow-out for the current bit pair.
  always_comb begin
    d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    sd_d  = {d_bit, sd_q[W-1:1]};
  end

  // The oldest result bit falls off the shifter; it already lives in diff_q by then.
  assign unused_sd0 = sd_q[0];

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a[W-1];
            b_msb_q <= b[W-1];
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          br_q  <= br_d;
          sd_q  <= sd_d;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          // Last bit: publish the assembled result together with the done pulse.
          if (cnt_q == CNT_LAST) begin
            diff_q  <= sd_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor: driver pushes arithmetic-model results, monitor checks on done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W+1:0] hold_v = '0;
  int           acc_cyc = -100;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, packed as {ovf, bout, diff}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    logic         bo, ov;
    int           r;
    d  = x - y;
    bo = (x < y);
    r  = int'($signed(x)) - int'($signed(y));
`ifdef SERIAL_SUB_OVF_EN
    ov = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
`else
    ov = 1'b0;
    if (r == 0) ov = 1'b0;
`endif
    return {ov, bo, d};
  endfunction

  // Driver: one clock of stimulus; acceptance decided from the handshake rules
  task automatic drive_cycle(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    #1;
    start = s;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    if (s && rst_n && (cyc >= acc_cyc + W + 1)) begin
      acc_cyc = cyc;
      exp_q.push_back(model(x, y));
      exp_cyc_q.push_back(cyc + W);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    acc_cyc = -100;
    hold_v  = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'({ovf, bout, diff}), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: busy window, done timing, result hold and scoreboard pop
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'((cyc >= acc_cyc) && (cyc <= acc_cyc + W - 1)));
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
        end else begin
          hold_v = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_done at cycle %0d: got done=0 expected done=1", cyc);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      chk("result", 32'({ovf, bout, diff}), 32'(hold_v));
    end
  end

  // Stimulus sequence
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'({ovf, bout, diff}), 32'd0);
    #1;
    rst_n = 1'b1;
    idle(2);

    drive_cycle(1'b1, 8'h35, 8'h12); idle(W + 2);
    drive_cycle(1'b1, 8'h12, 8'h35); idle(W + 2);
    drive_cycle(1'b1, 8'h80, 8'h01); idle(W + 2);
    drive_cycle(1'b1, 8'h00, 8'h01); idle(W + 2);
    drive_cycle(1'b1, 8'h7F, 8'hFF); idle(W + 2);

    // Restart attempt mid-operation must be ignored
    drive_cycle(1'b1, 8'h35, 8'h12);
    idle(2);
    drive_cycle(1'b1, 8'hFF, 8'h00);
    idle(W + 2);

    // Abort mid-operation, then a fresh operation
    drive_cycle(1'b1, 8'h35, 8'h12);
    idle(3);
    do_reset();
    drive_cycle(1'b1, 8'h05, 8'h07); idle(W + 2);

    // start held high: back-to-back operations through DONE
    for (int i = 0; i < 4 * (W + 1) + 2; i++) drive_cycle(1'b1, W'($urandom), W'($urandom));
    idle(W + 2);

    // Random start pattern with random operands
    for (int i = 0; i < 400; i++)
      drive_cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    idle(W + 3);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
